// File: rtl/sprite_layer_generator.sv
// Object-layer generator: once per frame, fetches N_OBJ object records from RAM into shadow registers
// and commits them in a single cycle. Every pixel, it emits the colour and rotation of the highest-priority object hit.
module sprite_layer_generator #(
    parameter int unsigned N_OBJ     = 3,
    parameter int unsigned COORD_W   = 9,
    parameter int unsigned POS_W     = 7,
    parameter int unsigned POS_SHIFT = 2,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned LOAD_LINE = 480
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [7:0]         i_ram_data,
    output logic               o_ram_rd,
    output logic [ADDR_W-1:0]  o_ram_adress,
    output logic [5:0]         o_layer_data,
    output logic [1:0]         o_rotate,
    output logic               o_hit,
    output logic               o_busy
);
    localparam int unsigned N_BYTES = 4 * N_OBJ;
    localparam int unsigned CNT_W   = $clog2(N_BYTES + 1);
    localparam int unsigned EXT_W   = COORD_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [COORD_W-1:0] r_x, r_y;
    logic [7:0]         shadow [N_BYTES];
    logic [7:0]         active [N_BYTES];

    logic               trigger_c;
    logic               rd_d, busy_d;
    logic [ADDR_W-1:0]  addr_d;
    logic               capture_c, commit_c;
    logic [CNT_W-1:0]   capture_idx_c;
    logic [N_OBJ-1:0]   obj_hit_c;
    logic [5:0]         color_c;
    logic [1:0]         rot_c;
    logic               hit_c;

    assign trigger_c     = (r_x == '0) && (r_y == COORD_W'(LOAD_LINE));
    assign capture_idx_c = cnt - CNT_W'(1);

    // State register, registered coordinates and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            r_x          <= '0;
            r_y          <= '0;
            o_ram_rd     <= 1'b0;
            o_ram_adress <= '0;
            o_busy       <= 1'b0;
            o_layer_data <= '0;
            o_rotate     <= '0;
            o_hit        <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            r_x          <= i_x;
            r_y          <= i_y;
            o_ram_rd     <= rd_d;
            o_ram_adress <= addr_d;
            o_busy       <= busy_d;
            o_layer_data <= color_c;
            o_rotate     <= rot_c;
            o_hit        <= hit_c;
        end
    end

    // Shadow capture trails each read by one cycle; the last byte bypasses shadow straight into the commit
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(N_BYTES); i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (capture_c) begin
                shadow[capture_idx_c] <= i_ram_data;
            end
            if (commit_c) begin
                for (int i = 0; i < int'(N_BYTES); i++) begin
                    active[i] <= (i == int'(N_BYTES) - 1) ? i_ram_data : shadow[i];
                end
            end
        end
    end

    // Next-state and load sequencing
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        rd_d      = 1'b0;
        addr_d    = o_ram_adress;
        capture_c = 1'b0;
        commit_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (trigger_c) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    rd_d    = 1'b1;
                    addr_d  = ADDR_W'(BASE_ADDR);
                end
            end
            S_LOAD: begin
                cnt_d     = cnt + CNT_W'(1);
                capture_c = (cnt != '0);
                if (cnt == CNT_W'(N_BYTES)) begin
                    commit_c = 1'b1;
                    cnt_d    = cnt;
                    state_d  = S_WAIT;
                end else if (cnt != CNT_W'(N_BYTES - 1)) begin
                    rd_d   = 1'b1;
                    addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(cnt + CNT_W'(1));
                end
            end
            S_WAIT: begin
                if (!trigger_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_LOAD);
    end

    // Per-object coverage test in COORD_W+1 bits so extents past the screen edge clip instead of wrapping
    for (genvar k = 0; k < int'(N_OBJ); k++) begin : g_obj
        logic [EXT_W-1:0] x0, y0, x1, y1, px, py;
        assign px = EXT_W'(r_x);
        assign py = EXT_W'(r_y);
        assign x0 = EXT_W'(active[4*k][POS_W-1:0]) << POS_SHIFT;
        assign y0 = EXT_W'(active[4*k+1][POS_W-1:0]) << POS_SHIFT;
        assign x1 = x0 + ((EXT_W'(active[4*k+2][7:4]) + EXT_W'(1)) << POS_SHIFT);
        assign y1 = y0 + ((EXT_W'(active[4*k+2][3:0]) + EXT_W'(1)) << POS_SHIFT);
        assign obj_hit_c[k] = (active[4*k+3][5:0] != 6'd0) &&
                              (px >= x0) && (px < x1) && (py >= y0) && (py < y1);
    end

    // Lowest index wins: scan from the highest index so lower ones overwrite
    always_comb begin
        color_c = '0;
        rot_c   = '0;
        hit_c   = 1'b0;
        for (int k = int'(N_OBJ) - 1; k >= 0; k--) begin
            if (obj_hit_c[k]) begin
                color_c = active[4*k+3][5:0];
                rot_c   = active[4*k+3][7:6];
                hit_c   = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sprite_layer_generator.sv
// Self-checking bench for sprite_layer_generator: a frame-level behavioural model checked every cycle,
// plus directed pixel and load-sequence checks with hand-computed values.
module tb_sprite_layer_generator;
    localparam int N_OBJ     = 3;
    localparam int NB        = 4 * N_OBJ;
    localparam int LOAD_LINE = 480;
    localparam int BASE_ADDR = 0;

    logic       i_clk   = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [8:0] i_x     = '0;
    logic [8:0] i_y     = '0;
    logic [7:0] i_ram_data;
    logic       o_ram_rd;
    logic [5:0] o_ram_adress;
    logic [5:0] o_layer_data;
    logic [1:0] o_rotate;
    logic       o_hit;
    logic       o_busy;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    sprite_layer_generator #(
        .N_OBJ(3), .COORD_W(9), .POS_W(7), .POS_SHIFT(2),
        .ADDR_W(6), .BASE_ADDR(0), .LOAD_LINE(480)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_x(i_x), .i_y(i_y),
        .i_ram_data(i_ram_data), .o_ram_rd(o_ram_rd), .o_ram_adress(o_ram_adress),
        .o_layer_data(o_layer_data), .o_rotate(o_rotate), .o_hit(o_hit), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Game-state RAM with one cycle of read latency
    logic [7:0] mem [64];
    logic [7:0] ram_q = '0;
    always @(posedge i_clk) if (o_ram_rd) ram_q <= mem[o_ram_adress];
    assign i_ram_data = ram_q;

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Frame-level model: committed object table as plain integers
    int act_m [NB];
    int exp_data, exp_rot, exp_hit, exp_rd, exp_addr, exp_busy;
    int px_d, py_d, t_load;
    bit loading, trig_prev, trig_now;

    task automatic model_pix(input int px, input int py, output int c, output int r, output int h);
        c = 0; r = 0; h = 0;
        for (int k = N_OBJ - 1; k >= 0; k--) begin
            int ox, oy, ow, oh, col;
            ox  = (act_m[4*k] % 128) * 4;
            oy  = (act_m[4*k+1] % 128) * 4;
            ow  = (act_m[4*k+2] / 16 + 1) * 4;
            oh  = (act_m[4*k+2] % 16 + 1) * 4;
            col = act_m[4*k+3] % 64;
            if (col != 0 && px >= ox && px < ox + ow && py >= oy && py < oy + oh) begin
                c = col; r = act_m[4*k+3] / 64; h = 1;
            end
        end
    endtask

    always @(posedge i_clk) begin
        if (!i_rst_n) begin
            exp_data = 0; exp_rot = 0; exp_hit = 0; exp_rd = 0; exp_addr = 0; exp_busy = 0;
            for (int i = 0; i < NB; i++) act_m[i] = 0;
            loading = 1'b0; trig_prev = 1'b0; t_load = 0; px_d = 0; py_d = 0;
        end else begin
            model_pix(px_d, py_d, exp_data, exp_rot, exp_hit);
            if (loading) begin
                t_load++;
                exp_rd   = (t_load <= NB) ? 1 : 0;
                exp_busy = (t_load <= NB + 1) ? 1 : 0;
                if (t_load <= NB) exp_addr = BASE_ADDR + t_load - 1;
                if (t_load == NB + 2) begin
                    for (int i = 0; i < NB; i++) act_m[i] = int'(mem[BASE_ADDR + i]);
                    loading = 1'b0;
                end
            end else begin
                exp_rd = 0; exp_busy = 0;
            end
            // A load begins when the trigger coordinate first appears while no load is running
            trig_now = (int'(i_x) == 0) && (int'(i_y) == LOAD_LINE);
            if (trig_now && !trig_prev && !loading) begin
                loading = 1'b1; t_load = 0;
            end
            trig_prev = trig_now;
            px_d = int'(i_x);
            py_d = int'(i_y);
        end
    end

    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("layer_data", int'(o_layer_data), exp_data);
            chk("rotate", int'(o_rotate), exp_rot);
            chk("hit", int'(o_hit), exp_hit);
            chk("ram_rd", int'(o_ram_rd), exp_rd);
            chk("ram_adress", int'(o_ram_adress), exp_addr);
            chk("busy", int'(o_busy), exp_busy);
        end
    end

    task automatic cyc(input int x, input int y);
        i_x = 9'(x);
        i_y = 9'(y);
        @(negedge i_clk);
    endtask

    task automatic pix(input int x, input int y, input int c, input int r, input int h);
        cyc(x, y);
        cyc(x, y);
        chk("pix_data", int'(o_layer_data), c);
        chk("pix_rot", int'(o_rotate), r);
        chk("pix_hit", int'(o_hit), h);
        chk("model_data", exp_data, c);
        chk("model_hit", exp_hit, h);
    endtask

    task automatic do_load(input int hold);
        int rdn, bn;
        rdn = 0; bn = 0;
        for (int i = 0; i < 22; i++) begin
            if (i < hold) cyc(0, LOAD_LINE);
            else          cyc(300, 300);
            if (o_ram_rd) begin
                chk("addr_seq", int'(o_ram_adress), BASE_ADDR + rdn);
                rdn++;
            end
            if (o_busy) bn++;
        end
        chk("rd_cycles", rdn, NB);
        chk("busy_cycles", bn, NB + 1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        // obj0 8x32 px at (40,80); obj1 32x32 px at same origin (off); obj2 at x=508 clipped (off)
        mem[0] = 8'd10;  mem[1] = 8'd20; mem[2]  = 8'h17; mem[3]  = 8'h45;
        mem[4] = 8'd10;  mem[5] = 8'd20; mem[6]  = 8'h77; mem[7]  = 8'h00;
        mem[8] = 8'd127; mem[9] = 8'd0;  mem[10] = 8'hF3; mem[11] = 8'h00;

        i_rst_n = 1'b0;
        i_x = 9'd100; i_y = 9'd100;
        @(negedge i_clk);
        chk_en = 1'b1;
        repeat (3) cyc(100, 100);
        chk("rst_hit", int'(o_hit), 0);
        chk("rst_data", int'(o_layer_data), 0);
        chk("rst_rd", int'(o_ram_rd), 0);
        chk("rst_busy", int'(o_busy), 0);
        i_rst_n = 1'b1;
        pix(40, 80, 0, 0, 0);

        do_load(5);
        pix(40, 80, 5, 1, 1);
        pix(47, 111, 5, 1, 1);
        pix(48, 80, 0, 0, 0);
        pix(40, 112, 0, 0, 0);
        pix(71, 111, 0, 0, 0);

        // RAM edits mid-frame stay invisible until the next commit
        mem[7] = 8'h49; mem[11] = 8'h8A;
        pix(40, 80, 5, 1, 1);
        pix(60, 80, 0, 0, 0);
        pix(508, 0, 0, 0, 0);
        do_load(1);
        pix(40, 80, 5, 1, 1);
        pix(60, 80, 9, 1, 1);

        mem[3] = 8'h00;
        do_load(1);
        pix(40, 80, 9, 1, 1);

        pix(508, 0, 10, 2, 1);
        pix(511, 15, 10, 2, 1);
        pix(511, 16, 0, 0, 0);
        for (int x = 0; x < 60; x++) pix(x, 0, 0, 0, 0);

        // Reset during LOAD cycle 6
        cyc(0, LOAD_LINE);
        repeat (7) cyc(300, 300);
        chk("midload_rd", int'(o_ram_rd), 1);
        i_rst_n = 1'b0;
        cyc(300, 300);
        chk("abort_rd", int'(o_ram_rd), 0);
        chk("abort_busy", int'(o_busy), 0);
        chk("abort_hit", int'(o_hit), 0);
        i_rst_n = 1'b1;
        pix(40, 80, 0, 0, 0);
        do_load(1);
        pix(40, 80, 9, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
